// File: rtl/jt12_wrdec.sv
// jt12_wrdec: CPU write decoder for the FM core.
// Turns address/data bus writes into per-field update strobes plus held
// channel/operator/data, keeps the global and ch3 special-mode registers,
// and runs the strobe/busy handshake with the channel/operator register stage.
module jt12_wrdec (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        write,
   input  logic [1:0]  addr,
   input  logic [7:0]  din,
   input  logic        busy,
   output logic        busy_o,
   output logic [7:0]  dout,
   output logic [2:0]  ch,
   output logic [1:0]  op,
   output logic        up_keyon,
   output logic        up_alg,
   output logic        up_block,
   output logic        up_fnumlo,
   output logic        up_pms,
   output logic        up_dt1,
   output logic        up_tl,
   output logic        up_ks_ar,
   output logic        up_amen_d1r,
   output logic        up_d2r,
   output logic        up_d1l,
   output logic        up_ssgeg,
   output logic        lfo_en,
   output logic [2:0]  lfo_freq,
   output logic [9:0]  value_A,
   output logic [7:0]  value_B,
   output logic        load_A,
   output logic        load_B,
   output logic        en_irq_A,
   output logic        en_irq_B,
   output logic        clr_flag_A,
   output logic        clr_flag_B,
   output logic        effect,
   output logic        csm,
   output logic [10:0] fnum_ch3op1,
   output logic [10:0] fnum_ch3op2,
   output logic [10:0] fnum_ch3op3,
   output logic [2:0]  block_ch3op1,
   output logic [2:0]  block_ch3op2,
   output logic [2:0]  block_ch3op3,
   output logic        dacen,
   output logic [7:0]  pcm
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HOLD = 2'd2,
      ST_REL  = 2'd3
   } state_t;

   // one-hot strobe vector bit positions
   localparam int B_KEYON  = 11;
   localparam int B_ALG    = 10;
   localparam int B_BLOCK  = 9;
   localparam int B_FNUMLO = 8;
   localparam int B_PMS    = 7;
   localparam int B_DT1    = 6;
   localparam int B_TL     = 5;
   localparam int B_KS_AR  = 4;
   localparam int B_AMEN   = 3;
   localparam int B_D2R    = 2;
   localparam int B_D1L    = 1;
   localparam int B_SSGEG  = 0;

   state_t      state_r;
   logic [7:0]  sel_r;
   logic        part_r;
   logic [5:0]  hi_op1_r;
   logic [5:0]  hi_op2_r;
   logic [5:0]  hi_op3_r;
   logic [11:0] up_r;
   logic [11:0] hs_sel_s;
   logic        data_wr_s;
   logic        glb_wr_s;

   // data writes are only honoured while the CPU sees the chip as not busy
   assign data_wr_s = write & addr[0] & ~busy_o;
   assign glb_wr_s  = data_wr_s & ~part_r & (sel_r[7:4] == 4'h2);

   assign up_keyon    = up_r[B_KEYON];
   assign up_alg      = up_r[B_ALG];
   assign up_block    = up_r[B_BLOCK];
   assign up_fnumlo   = up_r[B_FNUMLO];
   assign up_pms      = up_r[B_PMS];
   assign up_dt1      = up_r[B_DT1];
   assign up_tl       = up_r[B_TL];
   assign up_ks_ar    = up_r[B_KS_AR];
   assign up_amen_d1r = up_r[B_AMEN];
   assign up_d2r      = up_r[B_D2R];
   assign up_d1l      = up_r[B_D1L];
   assign up_ssgeg    = up_r[B_SSGEG];

   // Decode the latched address into the strobe that a data write would raise
   always_comb begin
      hs_sel_s = 12'd0;
      if (!part_r && (sel_r == 8'h28)) begin
         hs_sel_s[B_KEYON] = 1'b1;
      end else if ((sel_r < 8'h30) || (sel_r[1:0] == 2'd3)) begin
         hs_sel_s = 12'd0;
      end else begin
         case (sel_r[7:4])
            4'h3: hs_sel_s[B_DT1]   = 1'b1;
            4'h4: hs_sel_s[B_TL]    = 1'b1;
            4'h5: hs_sel_s[B_KS_AR] = 1'b1;
            4'h6: hs_sel_s[B_AMEN]  = 1'b1;
            4'h7: hs_sel_s[B_D2R]   = 1'b1;
            4'h8: hs_sel_s[B_D1L]   = 1'b1;
            4'h9: hs_sel_s[B_SSGEG] = 1'b1;
            4'hA: begin
               case (sel_r[3:2])
                  2'd0:    hs_sel_s[B_FNUMLO] = 1'b1;
                  2'd1:    hs_sel_s[B_BLOCK]  = 1'b1;
                  default: hs_sel_s = 12'd0;   // A8-AF are ch3 registers
               endcase
            end
            4'hB: begin
               case (sel_r[3:2])
                  2'd0:    hs_sel_s[B_ALG] = 1'b1;
                  2'd1:    hs_sel_s[B_PMS] = 1'b1;
                  default: hs_sel_s = 12'd0;
               endcase
            end
            default: hs_sel_s = 12'd0;
         endcase
      end
   end

   // Address latch: always accepted, even while a handshake is running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_r  <= 8'd0;
         part_r <= 1'b0;
      end else if (write && !addr[0]) begin
         sel_r  <= din;
         part_r <= addr[1];
      end
   end

   // Global LFO/timer/DAC registers, applied directly without a handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfo_en     <= 1'b0;
         lfo_freq   <= 3'd0;
         value_A    <= 10'd0;
         value_B    <= 8'd0;
         load_A     <= 1'b0;
         load_B     <= 1'b0;
         en_irq_A   <= 1'b0;
         en_irq_B   <= 1'b0;
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         effect     <= 1'b0;
         csm        <= 1'b0;
         pcm        <= 8'd0;
         dacen      <= 1'b0;
      end else begin
         clr_flag_A <= 1'b0;
         clr_flag_B <= 1'b0;
         if (glb_wr_s) begin
            case (sel_r[3:0])
               4'h2: begin
                  lfo_en   <= din[3];
                  lfo_freq <= din[2:0];
               end
               4'h4: value_A[9:2] <= din;
               4'h5: value_A[1:0] <= din[1:0];
               4'h6: value_B <= din;
               4'h7: begin
                  load_A     <= din[0];
                  load_B     <= din[1];
                  en_irq_A   <= din[2];
                  en_irq_B   <= din[3];
                  clr_flag_A <= din[4];
                  clr_flag_B <= din[5];
                  effect     <= |din[7:6];
                  csm        <= (din[7:6] == 2'b10);
               end
               4'hA: pcm   <= din;
               4'hB: dacen <= din[7];
               default: ;
            endcase
         end
      end
   end

   // Ch3 special-mode frequencies: high byte latched first, low byte loads both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_op1_r     <= 6'd0;
         hi_op2_r     <= 6'd0;
         hi_op3_r     <= 6'd0;
         fnum_ch3op1  <= 11'd0;
         fnum_ch3op2  <= 11'd0;
         fnum_ch3op3  <= 11'd0;
         block_ch3op1 <= 3'd0;
         block_ch3op2 <= 3'd0;
         block_ch3op3 <= 3'd0;
      end else if (data_wr_s) begin
         case (sel_r)
            8'hAC: hi_op3_r <= din[5:0];
            8'hAD: hi_op1_r <= din[5:0];
            8'hAE: hi_op2_r <= din[5:0];
            8'hA8: {block_ch3op3, fnum_ch3op3} <= {hi_op3_r, din};
            8'hA9: {block_ch3op1, fnum_ch3op1} <= {hi_op1_r, din};
            8'hAA: {block_ch3op2, fnum_ch3op2} <= {hi_op2_r, din};
            default: ;
         endcase
      end
   end

   // Handshake FSM: strobe out, wait for busy rise then fall, keep the strobe
   // low across one clk_en so the register stage sees the next write as new
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         busy_o  <= 1'b0;
         up_r    <= 12'd0;
         dout    <= 8'd0;
         ch      <= 3'd0;
         op      <= 2'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (data_wr_s && (hs_sel_s != 12'd0)) begin
                  dout    <= din;
                  ch      <= {part_r, sel_r[1:0]};
                  op      <= sel_r[3:2];
                  up_r    <= hs_sel_s;
                  busy_o  <= 1'b1;
                  state_r <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (busy) begin
                  state_r <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!busy) begin
                  up_r    <= 12'd0;
                  state_r <= ST_REL;
               end
            end
            ST_REL: begin
               if (clk_en) begin
                  busy_o  <= 1'b0;
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               up_r    <= 12'd0;
               busy_o  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
